mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and select sequencer for a 4:1 mux datapath.
- Four requesters (a,b,c,d) each present a data word and a request. The block grants one requester at a time and drives the mux select `s`.
- It registers the selected data onto `o` with a `valid` qualifier.
- A hold limit bounds how long one requester can keep the mux while others wait.

---
 rtl/mux4_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 mux datapath.
// Grants one of four requesters, drives the registered mux select and
// registers the selected data with a valid qualifier. A hold limit forces
// rotation when another requester waits.
// Optional feature: define MUX4_ARB_LOCK_EN to add a `lock` input that
// suppresses forced rotation while the current owner keeps requesting.
module mux4_rr_arbiter #(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MUX4_ARB_LOCK_EN
    input  logic              lock,
`endif
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        gnt,
    output logic [1:0]        s,
    output logic [DATA_W-1:0] o,
    output logic              valid
);

    localparam int unsigned      HOLD_W   = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        gnt_d;
    logic [1:0]        s_d;
    logic [1:0]        pick_c;
    logic              others_c;
    logic              lock_c;
    logic [DATA_W-1:0] sel_data_c;

`ifdef MUX4_ARB_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    // First set request scanning upward from last+1 (mod 4); the current
    // owner (index last) is reached only after all others.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] win;
        logic [1:0] idx;
        win = l;
        for (int k = 4; k >= 1; k--) begin
            idx = l + 2'(k);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign pick_c   = rr_pick(req, last_q);
    assign others_c = (req & ~gnt) != 4'b0000;

    // Next-state, grant, select and hold counter logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        s_d     = s;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_c;
                    s_d     = pick_c;
                    last_d  = pick_c;
                    hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (!req[s]) begin
                    if (req != 4'b0000) begin
                        gnt_d  = 4'b0001 << pick_c;
                        s_d    = pick_c;
                        last_d = pick_c;
                        hold_d = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX && others_c && !lock_c) begin
                    gnt_d  = 4'b0001 << pick_c;
                    s_d    = pick_c;
                    last_d = pick_c;
                    hold_d = HOLD_ONE;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // FSM state and registered grant/select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            hold_q  <= '0;
            gnt     <= 4'b0000;
            s       <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            s       <= s_d;
        end
    end

    // Mux of the four data inputs by the current select
    always_comb begin
        sel_data_c = a;
        case (s)
            2'd0:    sel_data_c = a;
            2'd1:    sel_data_c = b;
            2'd2:    sel_data_c = c;
            default: sel_data_c = d;
        endcase
    end

    // Registered output data, updated only while the owner still requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= (gnt != 4'b0000) && req[s];
            if ((gnt != 4'b0000) && req[s]) begin
                o <= sel_data_c;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed vector table plus hand-written
// sequences for reset, fairness, drop-at-rotation and (optionally) lock.
module tb_mux4_rr_arbiter;

    localparam int unsigned DW = 1;

    logic          clk;
    logic          rst_n;
    logic          lock;
    logic [3:0]    req;
    logic [DW-1:0] a, b, c, d;
    logic [3:0]    gnt;
    logic [1:0]    s;
    logic [DW-1:0] o;
    logic          valid;

    int n_checks;
    int n_fail;

    mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MUX4_ARB_LOCK_EN
        .lock  (lock),
`endif
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .s     (s),
        .o     (o),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] dat;   // {d,c,b,a}
        logic [3:0] gnt;
        logic [1:0] s;
        logic       v;
        logic       o;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] dat);
        req = r;
        a   = dat[0];
        b   = dat[1];
        c   = dat[2];
        d   = dat[3];
    endtask

    // One clock edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic eo);
        chk({tag, ".gnt"},   32'(gnt),   32'(eg));
        chk({tag, ".s"},     32'(s),     32'(es));
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".o"},     32'(o),     32'(eo));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            req      dat      gnt      s     v     o
        vecs[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[4]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1};
        vecs[5]  = '{4'b1001, 4'b0011, 4'b1000, 2'd3, 1'b0, 1'b1};
        vecs[6]  = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[8]  = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[10] = '{4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[12] = '{4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[14] = '{4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[15] = '{4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[16] = '{4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[17] = '{4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[18] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1};

        // Power-on reset
        rst_n = 1'b0;
        lock  = 1'b0;
        set_in(4'b0000, 4'b0000);
        #2;
        chk_out("por", 4'b0000, 2'd0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        // Directed vector table: single request, owner drop, sole requester
        for (int i = 0; i < 19; i++) begin
            set_in(vecs[i].req, vecs[i].dat);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].v, vecs[i].o);
        end

        // Build up a live grant, then reset mid-cycle: outputs clear at once
        set_in(4'b1111, 4'b0010);
        step();
        chk("pre_rst.gnt", 32'(gnt), 32'(4'b0010));
        step();
        chk("pre_rst.o", 32'(o), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;

        // Fairness: all requesting, rotation every MAX_HOLD cycles
        set_in(4'b1111, 4'b0101);
        for (int i = 0; i < 20; i++) begin
            int own;
            int prv;
            own = (i / 4) % 4;
            prv = ((i - 1) / 4) % 4;
            step();
            chk($sformatf("fair%0d.gnt", i), 32'(gnt), 32'(4'b0001 << own));
            chk($sformatf("fair%0d.s", i), 32'(s), 32'(own));
            if (i == 0) begin
                chk("fair0.valid", 32'(valid), 32'(0));
            end else begin
                chk($sformatf("fair%0d.valid", i), 32'(valid), 32'(1));
                chk($sformatf("fair%0d.o", i), 32'(o), 32'((prv % 2 == 0) ? 1 : 0));
            end
        end

        // All requests drop exactly at a forced-rotation edge: go idle
        set_in(4'b0000, 4'b0101);
        step();
        chk_out("drop_at_rot", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk("drop_idle.gnt", 32'(gnt), 32'(4'b0000));

`ifdef MUX4_ARB_LOCK_EN
        // Lock suppresses forced rotation; release rotates at once
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_in(4'b0011, 4'b0001);
        lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("lock%0d.gnt", i), 32'(gnt), 32'(4'b0001));
        end
        lock = 1'b0;
        step();
        chk("unlock.gnt", 32'(gnt), 32'(4'b0010));
        chk("unlock.s", 32'(s), 32'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
